// File: rtl/sprite_frame_scheduler_if.sv
// Update channel from game logic into sprite_frame_scheduler: one sprite
// position/visibility record per valid/ready transfer.
interface sprite_frame_scheduler_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_id;
    logic [10:0] upd_x;
    logic [10:0] upd_y;
    logic        upd_en;

    modport master (
        output upd_valid, upd_id, upd_x, upd_y, upd_en,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_id, upd_x, upd_y, upd_en,
        output upd_ready
    );
endinterface

// File: rtl/sprite_frame_scheduler.sv
// Sprite scheduler: buffers position updates, commits them in vertical blank and
// arbitrates sprites per pixel (2-clock pipeline). SPRITE_COLLISION_EN enables collide.
module sprite_frame_scheduler #(
    parameter int NSPR     = 4,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPR_W    = 40,
    parameter int SPR_H    = 40
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10:0]                    counth,
    input  logic [10:0]                    countv,
    sprite_frame_scheduler_if.slave        upd,
    output logic                           frame_done,
    output logic                           layer_hit,
    output logic [1:0]                     layer_id,
    output logic [5:0]                     off_x,
    output logic [5:0]                     off_y,
    output logic                           collide
);

    localparam int CW = (NSPR > 1) ? $clog2(NSPR) : 1;

    typedef enum logic [1:0] {RUN, COMMIT, BLANK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            cnt_last;
    logic            accept;
    logic            id_ok;

    logic [10:0]     sh_x  [NSPR];
    logic [10:0]     sh_y  [NSPR];
    logic [NSPR-1:0] sh_en;
    logic [NSPR-1:0] dirty;
    logic [10:0]     act_x [NSPR];
    logic [10:0]     act_y [NSPR];
    logic [NSPR-1:0] act_en;

    logic [NSPR-1:0] hit_c;
    logic [NSPR-1:0] s1_hit;
    logic [5:0]      s1_dx [NSPR];
    logic [5:0]      s1_dy [NSPR];

    logic            win_hit;
    logic [1:0]      win_id;
    logic [5:0]      win_dx, win_dy;

    assign accept = upd.upd_valid & upd.upd_ready;
    assign id_ok  = 32'(upd.upd_id) < NSPR;

    always_comb begin
        state_d  = state_q;
        cnt_last = (cnt_q == CW'(NSPR - 1));
        case (state_q)
            RUN:     if (countv == 11'(V_ACTIVE) && counth == '0) state_d = COMMIT;
            COMMIT:  if (cnt_last) state_d = BLANK;
            BLANK:   if (countv == '0 && counth == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            upd.upd_ready  <= 1'b1;
            frame_done     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= (state_q == COMMIT && !cnt_last) ? cnt_q + 1'b1 : '0;
            upd.upd_ready  <= (state_d != COMMIT);
            frame_done     <= (state_q == COMMIT) && (state_d == BLANK);
        end
    end

    // Accepts and commits never coincide: upd_ready is low for the whole COMMIT window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
            sh_en  <= '0;
            dirty  <= '0;
            act_en <= '0;
        end else begin
            if (accept && id_ok) begin
                sh_x[upd.upd_id]  <= upd.upd_x;
                sh_y[upd.upd_id]  <= upd.upd_y;
                sh_en[upd.upd_id] <= upd.upd_en;
                dirty[upd.upd_id] <= 1'b1;
            end
            if (state_q == COMMIT && dirty[cnt_q]) begin
                act_x[cnt_q]  <= sh_x[cnt_q];
                act_y[cnt_q]  <= sh_y[cnt_q];
                act_en[cnt_q] <= sh_en[cnt_q];
                dirty[cnt_q]  <= 1'b0;
            end
        end
    end

    // Bounds are compared at 12 bits so a sprite near 2047 cannot wrap onto column 0.
    always_comb begin
        hit_c = '0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            hit_c[i] = act_en[i]
                && ({1'b0, counth} >= {1'b0, act_x[i]})
                && ({1'b0, counth} <= {1'b0, act_x[i]} + 12'(SPR_W - 1))
                && ({1'b0, countv} >= {1'b0, act_y[i]})
                && ({1'b0, countv} <= {1'b0, act_y[i]} + 12'(SPR_H - 1))
                && (counth < 11'(H_ACTIVE))
                && (countv < 11'(V_ACTIVE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= '0;
            for (int unsigned i = 0; i < NSPR; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else begin
            s1_hit <= hit_c;
            for (int unsigned i = 0; i < NSPR; i++) begin
                s1_dx[i] <= counth[5:0] - act_x[i][5:0];
                s1_dy[i] <= countv[5:0] - act_y[i][5:0];
            end
        end
    end

    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        win_dx  = '0;
        win_dy  = '0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            if (s1_hit[i] && !win_hit) begin
                win_hit = 1'b1;
                win_id  = 2'(i);
                win_dx  = s1_dx[i];
                win_dy  = s1_dy[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_hit <= 1'b0;
            layer_id  <= '0;
            off_x     <= '0;
            off_y     <= '0;
        end else begin
            layer_hit <= win_hit;
            layer_id  <= win_id;
            off_x     <= win_dx;
            off_y     <= win_dy;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky  <= 1'b0;
            collide <= 1'b0;
        end else if (frame_done) begin
            collide <= sticky;
            sticky  <= 1'b0;
        end else if (s1_hit[0] && |s1_hit[NSPR-1:1]) begin
            sticky  <= 1'b1;
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Self-checking bench for sprite_frame_scheduler: table-driven pixel vectors
// through a 2-deep scoreboard, plus commit/reset sequences.
module tb_sprite_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] counth, countv;
    logic        frame_done, layer_hit, collide;
    logic [1:0]  layer_id;
    logic [5:0]  off_x, off_y;

    sprite_frame_scheduler_if bus ();

    sprite_frame_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .counth     (counth),
        .countv     (countv),
        .upd        (bus),
        .frame_done (frame_done),
        .layer_hit  (layer_hit),
        .layer_id   (layer_id),
        .off_x      (off_x),
        .off_y      (off_y),
        .collide    (collide)
    );

    always #5 clk = ~clk;

`ifdef SPRITE_COLLISION_EN
    localparam logic COL = 1'b1;
`else
    localparam logic COL = 1'b0;
`endif

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hit;
        logic [1:0]  id;
        logic [5:0]  ox;
        logic [5:0]  oy;
    } vec_t;

    typedef struct {
        int          tag;
        logic [14:0] expv;
    } sb_t;

    vec_t vecs [26];
    sb_t  sb [$];

    int tests = 0;
    int fails = 0;

    logic        want_rst;
    logic        pend_valid;
    logic [1:0]  pend_id;
    logic [10:0] pend_x, pend_y;
    logic        pend_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic setv(input int i, input int h, input int v, input int hit,
                        input int id, input int ox, input int oy);
        vecs[i].h   = 11'(h);
        vecs[i].v   = 11'(v);
        vecs[i].hit = 1'(hit);
        vecs[i].id  = 2'(id);
        vecs[i].ox  = 6'(ox);
        vecs[i].oy  = 6'(oy);
    endtask

    // Each call is one clock: compare the pixel driven two cycles ago, then drive the next.
    task automatic step(input int h, input int v, input logic [14:0] expv, input int tag);
        sb_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check($sformatf("pixel tag %0d {hit,id,offx,offy}", e.tag),
                  32'({layer_hit, layer_id, off_x, off_y}), 32'(e.expv));
        end
        rst           = want_rst;
        counth        = 11'(h);
        countv        = 11'(v);
        bus.upd_valid = pend_valid;
        bus.upd_id    = pend_id;
        bus.upd_x     = pend_x;
        bus.upd_y     = pend_y;
        bus.upd_en    = pend_en;
        if (pend_valid) check("upd_ready at accept", 32'(bus.upd_ready), 32'd1);
        pend_valid = 1'b0;
        sb.push_back('{tag, expv});
    endtask

    task automatic idle(input int h, input int v);
        step(h, v, '0, -1);
    endtask

    task automatic post(input int id, input int x, input int y, input int en);
        pend_valid = 1'b1;
        pend_id    = 2'(id);
        pend_x     = 11'(x);
        pend_y     = 11'(y);
        pend_en    = 1'(en);
        idle(700, 10);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            step(vecs[i].h, vecs[i].v,
                 {vecs[i].hit, vecs[i].id, vecs[i].ox, vecs[i].oy}, i);
        idle(700, 10);
        idle(700, 10);
    endtask

    task automatic run_commit(input logic exp_col);
        idle(0, 480);
        for (int k = 0; k < 4; k++) begin
            idle(1, 480);
            check($sformatf("upd_ready commit cycle %0d", k), 32'(bus.upd_ready), 32'd0);
            check($sformatf("frame_done commit cycle %0d", k), 32'(frame_done), 32'd0);
        end
        idle(1, 480);
        check("upd_ready first blank", 32'(bus.upd_ready), 32'd1);
        check("frame_done pulse", 32'(frame_done), 32'd1);
        idle(1, 480);
        check("frame_done one cycle", 32'(frame_done), 32'd0);
        check("collide after frame_done", 32'(collide), 32'(exp_col));
        idle(0, 0);
        idle(700, 10);
    endtask

    initial begin
        want_rst      = 1'b1;
        rst           = 1'b1;
        pend_valid    = 1'b0;
        pend_id       = '0;
        pend_x        = '0;
        pend_y        = '0;
        pend_en       = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_id    = '0;
        bus.upd_x     = '0;
        bus.upd_y     = '0;
        bus.upd_en    = 1'b0;
        counth        = 11'd700;
        countv        = 11'd10;

        // sprite 0 alone at (300,220)
        setv(0, 300, 220, 1, 0, 0, 0);
        setv(1, 339, 259, 1, 0, 39, 39);
        setv(2, 340, 259, 0, 0, 0, 0);
        setv(3, 299, 220, 0, 0, 0, 0);
        setv(4, 300, 219, 0, 0, 0, 0);
        setv(5, 320, 260, 0, 0, 0, 0);
        // s0,s2,s3 at (100,100), s1 at (120,100)
        setv(6, 110, 105, 1, 0, 10, 5);
        setv(7, 145, 110, 1, 1, 25, 10);
        setv(8, 130, 110, 1, 0, 30, 10);
        // s0 moved to (400,300), s2/s3 disabled
        setv(9, 110, 105, 0, 0, 0, 0);
        setv(10, 130, 110, 1, 1, 10, 10);
        setv(11, 400, 300, 1, 0, 0, 0);
        // s1 update pending, still old position
        setv(12, 125, 105, 1, 1, 5, 5);
        setv(13, 55, 105, 0, 0, 0, 0);
        // s1 committed at x=60 (last of two updates)
        setv(14, 125, 105, 0, 0, 0, 0);
        setv(15, 60, 100, 1, 1, 0, 0);
        setv(16, 99, 139, 1, 1, 39, 39);
        setv(17, 55, 105, 0, 0, 0, 0);
        // s3 at x=2040, s2 clipped at (620,460)
        setv(18, 5, 210, 0, 0, 0, 0);
        setv(19, 639, 479, 1, 2, 19, 19);
        setv(20, 640, 470, 0, 0, 0, 0);
        setv(21, 630, 480, 0, 0, 0, 0);
        // after reset during commit
        setv(22, 300, 220, 0, 0, 0, 0);
        setv(23, 639, 479, 0, 0, 0, 0);
        // s0 re-posted and committed after reset
        setv(24, 300, 220, 1, 0, 0, 0);
        setv(25, 320, 230, 1, 0, 20, 10);

        repeat (3) idle(700, 10);
        check("reset upd_ready", 32'(bus.upd_ready), 32'd1);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset layer_hit", 32'(layer_hit), 32'd0);
        check("reset layer_id", 32'(layer_id), 32'd0);
        check("reset off_x/off_y", 32'({off_x, off_y}), 32'd0);
        check("reset collide", 32'(collide), 32'd0);
        want_rst = 1'b0;
        idle(700, 10);

        post(0, 300, 220, 1);
        run_commit(1'b0);
        apply(0, 5);

        post(0, 100, 100, 1);
        post(1, 120, 100, 1);
        post(2, 100, 100, 1);
        post(3, 100, 100, 1);
        run_commit(1'b0);
        apply(6, 8);

        post(0, 400, 300, 1);
        post(2, 100, 100, 0);
        post(3, 100, 100, 0);
        run_commit(COL);
        apply(9, 11);

        post(1, 50, 100, 1);
        apply(12, 13);

        post(1, 60, 100, 1);
        run_commit(1'b0);
        apply(14, 17);

        post(3, 2040, 200, 1);
        post(2, 620, 460, 1);
        run_commit(1'b0);
        apply(18, 21);

        // reset lands on the edge that ends the second COMMIT cycle
        post(0, 300, 220, 1);
        idle(0, 480);
        idle(1, 480);
        check("upd_ready first commit cycle", 32'(bus.upd_ready), 32'd0);
        want_rst = 1'b1;
        idle(1, 480);
        want_rst = 1'b0;
        idle(1, 480);
        check("mid-commit reset upd_ready", 32'(bus.upd_ready), 32'd1);
        check("mid-commit reset frame_done", 32'(frame_done), 32'd0);
        check("mid-commit reset outputs", 32'({layer_hit, layer_id, off_x, off_y}), 32'd0);
        check("mid-commit reset collide", 32'(collide), 32'd0);
        idle(1, 480);
        check("mid-commit reset stays ready", 32'(bus.upd_ready), 32'd1);
        check("mid-commit reset no frame_done", 32'(frame_done), 32'd0);
        apply(22, 23);

        post(0, 300, 220, 1);
        run_commit(1'b0);
        apply(24, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
